// File: rtl/fpga_led_pkg.sv
// Shared types and the round-robin pick helper for the debug LED scheduler.
package fpga_led_pkg;

  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_SLOW, LED_FAST} led_mode_e;
  typedef enum logic {IDLE, SHOW} state_e;

  localparam int MAX_REQ = 32;
  localparam int PICK_W  = $clog2(MAX_REQ);

  // First set bit searching upward from ptr+1, wrapping; ptr itself is tried last.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input int n, input int ptr);
    logic              found;
    logic [PICK_W-1:0] pick;
    logic [PICK_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = PICK_W'((ptr + k) % n);
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fpga_led_sched_if.sv
// Requester-side bus of the LED scheduler: requests and modes in, grant/ack/LEDs out.
interface fpga_led_sched_if #(
  parameter int N_REQ = 4,
  parameter int N_LED = 4
);
  logic [N_REQ-1:0]         req_i;
  logic [N_REQ*N_LED*2-1:0] mode_i;
  logic [N_REQ-1:0]         grant_o;
  logic [N_REQ-1:0]         ack_o;
  logic                     busy_o;
  logic [N_LED-1:0]         led_o;

  modport master (output req_i, mode_i, input grant_o, ack_o, busy_o, led_o);
  modport slave  (input req_i, mode_i, output grant_o, ack_o, busy_o, led_o);
endinterface

// File: rtl/fpga_led_blink.sv
// Half-period toggle generator; phase_o restarts high with a zeroed count on clr_i.
module fpga_led_blink #(
  parameter int HALF = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic phase_o
);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_o <= 1'b1;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_o <= 1'b1;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_q   <= '0;
      phase_o <= ~phase_o;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/fpga_led_sched.sv
// Round-robin owner of the board debug LEDs with per-LED off/on/slow/fast modes.
// Optional idle heartbeat on led_o[0] when FPGA_LED_HEARTBEAT_EN is defined.
module fpga_led_sched
  import fpga_led_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int N_LED     = 4,
  parameter int DWELL_CYC = 50_000_000,
  parameter int SLOW_HALF = 25_000_000,
  parameter int FAST_HALF = 5_000_000,
  parameter int HB_HALF   = 50_000_000
) (
  input logic              clk_i,
  input logic              rst_ni,
  fpga_led_sched_if.slave  bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int DW = $clog2(DWELL_CYC);
  localparam int LW = 2 * N_LED;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [LW-1:0]     mode_q, mode_d;
  logic              blink_clr, idle_entry;
  logic              slow_phase, fast_phase;
  logic [N_LED-1:0]  led;

  logic [PICK_W-1:0] pick_full;
  logic [OW-1:0]     pick_idx;
  logic [LW-1:0]     mode_sel;
  logic              dwell_end, owner_drop, rearb;
  logic              unused_pick;

  assign pick_full   = rr_pick(MAX_REQ'(bus.req_i), N_REQ, int'(rr_q));
  assign pick_idx    = pick_full[OW-1:0];
  assign unused_pick = ^pick_full;
  assign mode_sel    = bus.mode_i[int'(pick_idx)*LW +: LW];

  assign dwell_end  = (state_q == SHOW) && (dwell_q == DW'(DWELL_CYC - 1));
  assign owner_drop = (state_q == SHOW) && !bus.req_i[rr_q];
  assign rearb      = (state_q == IDLE) || dwell_end || owner_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      rr_q    <= OW'(N_REQ - 1);
      dwell_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rr_q    <= rr_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  // Dwell end wins over an owner drop in the same cycle, so the ack is still issued.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    rr_d       = rr_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;
    blink_clr  = 1'b0;
    idle_entry = 1'b0;
    if (state_q == SHOW) dwell_d = dwell_q + DW'(1);
    if (dwell_end) ack_d = grant_q;
    if (rearb) begin
      if (|bus.req_i) begin
        state_d   = SHOW;
        grant_d   = N_REQ'(1) << pick_idx;
        rr_d      = pick_idx;
        dwell_d   = '0;
        mode_d    = mode_sel;
        blink_clr = 1'b1;
      end else begin
        state_d    = IDLE;
        grant_d    = '0;
        dwell_d    = '0;
        idle_entry = (state_q == SHOW);
      end
    end
  end

  fpga_led_blink #(.HALF(SLOW_HALF)) u_slow (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (blink_clr),
    .phase_o(slow_phase)
  );

  fpga_led_blink #(.HALF(FAST_HALF)) u_fast (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (blink_clr),
    .phase_o(fast_phase)
  );

`ifdef FPGA_LED_HEARTBEAT_EN
  logic hb_phase;

  // Inverted so the heartbeat reads low on every IDLE entry.
  fpga_led_blink #(.HALF(HB_HALF)) u_hb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (idle_entry),
    .phase_o(hb_phase)
  );
`else
  localparam int unused_hb_half = HB_HALF;
  logic unused_idle_entry;
  assign unused_idle_entry = idle_entry;
`endif

  always_comb begin
    led = '0;
    if (state_q == SHOW) begin
      for (int l = 0; l < N_LED; l++) begin
        case (led_mode_e'(mode_q[2*l +: 2]))
          LED_OFF:  led[l] = 1'b0;
          LED_ON:   led[l] = 1'b1;
          LED_SLOW: led[l] = slow_phase;
          LED_FAST: led[l] = fast_phase;
        endcase
      end
    end else begin
`ifdef FPGA_LED_HEARTBEAT_EN
      led[0] = ~hb_phase;
`else
      led = '0;
`endif
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.ack_o   = ack_q;
  assign bus.busy_o  = (state_q == SHOW);
  assign bus.led_o   = led;

endmodule

// File: tb/tb_fpga_led_sched.sv
// Directed self-checking bench for fpga_led_sched with short dwell and blink periods.
module tb_fpga_led_sched;
  localparam int N_REQ = 4;
  localparam int N_LED = 4;
  localparam int DWELL = 8;
  localparam int SLOW  = 4;
  localparam int FAST  = 1;
  localparam int HB    = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   test_count = 0;
  int   fail_count = 0;

  // Per requester byte: r0 on/off/slow/fast, r1 all on, r2 LED0-1 on, r3 all fast.
  logic [31:0] modes = 32'hFF05_55E1;

  always #5 clk = ~clk;

  fpga_led_sched_if #(.N_REQ(N_REQ), .N_LED(N_LED)) bus ();

  fpga_led_sched #(
    .N_REQ(N_REQ), .N_LED(N_LED), .DWELL_CYC(DWELL),
    .SLOW_HALF(SLOW), .FAST_HALF(FAST), .HB_HALF(HB)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    bus.req_i  = req;
    bus.mode_i = modes;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected LED bank k cycles into a grant.
  function automatic logic [3:0] ledModel(input logic [7:0] m, input int k);
    logic [3:0] v;
    for (int l = 0; l < 4; l++) begin
      case (m[2*l +: 2])
        2'b00:   v[l] = 1'b0;
        2'b01:   v[l] = 1'b1;
        2'b10:   v[l] = ((k / SLOW) % 2) == 0;
        default: v[l] = ((k / FAST) % 2) == 0;
      endcase
    end
    return v;
  endfunction

  initial begin
    int         owner;
    int         nxt;
    logic [3:0] exp_led;

    rst_n = 1'b1;
    applyStimulus(4'b0000);
    #1 rst_n = 1'b0;
    step();
    step();
    checkOutput("reset_state", {bus.ack_o, bus.grant_o, bus.busy_o, bus.led_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef FPGA_LED_HEARTBEAT_EN
      exp_led = 4'((i / HB) % 2);
`else
      exp_led = 4'b0000;
`endif
      checkOutput("idle", {bus.grant_o, bus.busy_o, bus.led_o}, {4'b0000, 1'b0, exp_led});
    end

    applyStimulus(4'b0001);
    step();
    checkOutput("grant_r0", {bus.grant_o, bus.busy_o}, {4'b0001, 1'b1});
    for (int k = 0; k < DWELL; k++) begin
      if (k > 0) step();
      checkOutput("blink_r0", bus.led_o, ledModel(modes[7:0], k));
      checkOutput("no_ack_r0", bus.ack_o, 4'b0000);
    end
    step();
    checkOutput("ack_regrant_r0", {bus.ack_o, bus.grant_o}, {4'b0001, 4'b0001});
    checkOutput("regrant_led_r0", bus.led_o, 4'b1101);

    applyStimulus(4'b1111);
    owner = 0;
    for (int g = 0; g < 5; g++) begin
      for (int k = 1; k < DWELL; k++) begin
        step();
        checkOutput("rot_hold", {bus.ack_o, bus.grant_o}, {4'b0000, 4'(1 << owner)});
      end
      step();
      nxt = (owner + 1) % N_REQ;
      checkOutput("rot_next", {bus.ack_o, bus.grant_o}, {4'(1 << owner), 4'(1 << nxt)});
      checkOutput("rot_led", bus.led_o, ledModel(modes[8*nxt +: 8], 0));
      owner = nxt;
    end

    // Owner is requester 1 at dwell 0; abort it at dwell 3.
    for (int k = 1; k <= 3; k++) step();
    applyStimulus(4'b1000);
    step();
    checkOutput("abort", {bus.ack_o, bus.grant_o}, {4'b0000, 4'b1000});

    for (int k = 1; k < DWELL; k++) step();
    applyStimulus(4'b0000);
    step();
    checkOutput("end_drop", {bus.ack_o, bus.grant_o, bus.busy_o, bus.led_o},
                {4'b1000, 4'b0000, 1'b0, 4'b0000});
    step();
    checkOutput("ack_pulse", bus.ack_o, 4'b0000);

    applyStimulus(4'b0100);
    step();
    checkOutput("grant_r2", bus.grant_o, 4'b0100);
    for (int k = 1; k <= 5; k++) step();
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset", {bus.ack_o, bus.grant_o, bus.busy_o, bus.led_o}, 32'h0);
    applyStimulus(4'b1101);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post_reset_grant", {bus.ack_o, bus.grant_o, bus.busy_o}, {4'b0000, 4'b0001, 1'b1});

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
